// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one instruction per request into the IR, presents it
// downstream, and advances or redirects the PC when the instruction is accepted.
`timescale 1ns/1ps
module instr_fetch #(
  parameter int unsigned   AW       = 5,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [AW+2:0]   imem_rdata,
  output logic [2:0]      opcode,
  output logic [AW-1:0]   operand_addr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            pc_src,
  input  logic            jmp_uncond,
  output logic [AW-1:0]   pc,
  output logic [15:0]     issue_cnt
);

  localparam int unsigned IW = AW + 3;
  localparam int unsigned CW = 16;

  typedef enum logic [0:0] {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;

  // State and datapath registers; req/valid are flops so no input reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath updates; ack only counts while a request is actually raised.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          state_d = FETCH;
          cnt_d   = cnt_q + CW'(1);
          if (pc_src && jmp_uncond) pc_d = ir_q[AW-1:0];
          else                      pc_d = pc_q + AW'(1);
        end
      end
      default: state_d = FETCH;
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign opcode       = ir_q[IW-1:AW];
  assign operand_addr = ir_q[AW-1:0];
  assign instr_valid  = valid_q;
  assign issue_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the fetch/issue protocol.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int unsigned AW   = 5;
  localparam int          NPC  = 1 << AW;
  localparam int          RPC  = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [AW+2:0] imem_rdata;
  logic [2:0]    opcode;
  logic [AW-1:0] operand_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic          pc_src;
  logic          jmp_uncond;
  logic [AW-1:0] pc;
  logic [15:0]   issue_cnt;

  instr_fetch #(.AW(AW), .RESET_PC(AW'(RPC))) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .operand_addr(operand_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .jmp_uncond(jmp_uncond),
    .pc(pc), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one in-flight instruction, a PC and an acceptance counter.
  int m_pc, m_cnt, m_instr;
  bit m_pending, m_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_cnt = 0; m_instr = 0; m_pending = 1'b0; m_req = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_pending) begin
      if (m_req && imem_ack) begin
        m_instr   = int'(imem_rdata);
        m_pending = 1'b1;
      end
    end else if (instr_ready) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (pc_src && jmp_uncond) m_pc = m_instr % NPC;
      else                      m_pc = (m_pc + 1) % NPC;
      m_pending = 1'b0;
    end
    if (rst_n) m_req = !m_pending;
  endtask

  task automatic check_all();
    chk("imem_req",     32'(imem_req),     32'(m_req));
    chk("imem_addr",    32'(imem_addr),    32'(m_pc));
    chk("pc",           32'(pc),           32'(m_pc));
    chk("instr_valid",  32'(instr_valid),  32'(m_pending));
    chk("opcode",       32'(opcode),       32'(m_instr / NPC));
    chk("operand_addr", 32'(operand_addr), 32'(m_instr % NPC));
    chk("issue_cnt",    32'(issue_cnt),    32'(m_cnt));
  endtask

  // One clock: model sees the pre-edge inputs, outputs are compared 1ns after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit ack, input bit rdy, input int rd, input bit src, input bit jmp);
    imem_ack    = ack;
    instr_ready = rdy;
    imem_rdata  = (AW+3)'(rd);
    pc_src      = src;
    jmp_uncond  = jmp;
  endtask

  // Fetch one instruction with zero wait, accept it immediately with the given PC select.
  task automatic one_instr(input int rd, input bit src, input bit jmp);
    drive(1'b1, 1'b0, rd, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 0, src, jmp);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    drive(1'b1, 1'b1, 8'hff, 1'b1, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    #0;
    chk("req_low_after_release", 32'(imem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    model_reset();
    #2;
    check_all();
    step();
    step();
    rst_n = 1'b1;
    #0;
    chk("req_low_after_release", 32'(imem_req), 32'd0);

    // Zero-wait memory, ready tied high, opcode i at address i.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b1, (m_pc % 8) * NPC + m_pc, 1'b0, 1'b0);
      step();
    end
    chk("stream_pc", 32'(pc), 32'd7);
    chk("stream_cnt", 32'(issue_cnt), 32'd7);

    // Ack after 3 idle cycles, ready after 2; rdata churns while issuing.
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 8'h11 + i, 1'b0, 1'b0); step(); end
    drive(1'b1, 1'b0, 8'h2C, 1'b0, 1'b0); step();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 8'h40 + i, 1'b1, 1'b1); step(); end
    chk("held_opcode", 32'(opcode), 32'd1);
    chk("held_operand", 32'(operand_addr), 32'd12);
    drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0); step();
    chk("slow_pc", 32'(pc), 32'd8);

    // Unconditional jump vs conditional-only select.
    one_instr(8'b111_01010, 1'b1, 1'b1);
    chk("jump_taken", 32'(imem_addr), 32'd10);
    one_instr(8'b111_01010, 1'b1, 1'b0);
    chk("jump_not_taken", 32'(imem_addr), 32'd11);

    // Wrap from all-ones, then a jump to self.
    one_instr(8'b000_11111, 1'b1, 1'b1);
    chk("at_top", 32'(imem_addr), 32'd31);
    one_instr(8'b001_00000, 1'b0, 1'b0);
    chk("wrap_to_zero", 32'(imem_addr), 32'd0);
    one_instr(8'b101_00000, 1'b1, 1'b1);
    chk("self_jump", 32'(imem_addr), 32'd0);

    // Reset mid-issue with pc=5, issue_cnt=3.
    do_reset();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0); step();
    one_instr(8'b100_00011, 1'b1, 1'b1);
    one_instr(8'b010_00000, 1'b0, 1'b0);
    one_instr(8'b010_00000, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'b011_00001, 1'b0, 1'b0); step();
    chk("pre_reset_pc", 32'(pc), 32'd5);
    chk("pre_reset_cnt", 32'(issue_cnt), 32'd3);
    chk("pre_reset_valid", 32'(instr_valid), 32'd1);
    do_reset();
    chk("post_reset_pc", 32'(pc), 32'(RPC));
    chk("post_reset_cnt", 32'(issue_cnt), 32'd0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0); step();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'(RPC));

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
              int'($urandom_range(0, 255)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
